stream_window_reduce_invoke: RTL and testbench
==============================================

# stream_window_reduce_invoke

Parametrised CFDF actor for the window-computation pipeline: it accepts a length and a command token, reduces a window of that many data tokens with the selected operation, and emits one result token. It replaces the fixed-function invoke/firing pair with a single self-contained controller. The controller follows the LWDF-V invoke / next_mode_in / FC / next_mode_out protocol and is driven by the same scheduler.

## Interface
- size, 3: maximum window length L accepted; 1 ≤ L ≤ size
- width, 10: bit width of data, length, command and result tokens (unsigned)
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- data_FIFO  in  width  head token of data FIFO (first-word-fall-through)
- length_FIFO  in  width  head token of length FIFO (FWFT)
- command_FIFO  in  width  head token of command FIFO (FWFT); low 2 bits used
- invoke  in  1  LWDF-V invoke, sampled only in IDLE
- next_mode_in  in  2  mode to fire: 00 SETUP_COMP, 01 COMP, 10 OUTPUT
- rd_in_data_FIFO / rd_in_length_FIFO / rd_in_command_FIFO  out  1 each  pop strobes; head consumed at that clock edge
- next_mode_out  out  2  mode for next firing, valid while FC=1
- FC  out  1  firing-complete pulse, one cycle
- wr_out_fifo1  out  1  output FIFO write strobe
- data_out  out  width  result token, valid while wr_out_fifo1=1
- err  out  1  sticky illegal-length flag

## Operation
- Top FSM: IDLE → START → RUN → DONE → IDLE.
- IDLE: leave only when invoke=1; latch next_mode_in into mode_r.
- START: one cycle. For COMP, clear the counter and load the accumulator: 0 for sum, 0 for max, all-ones for min.
- RUN
  - SETUP_COMP: one cycle. Pulse rd_in_length_FIFO and rd_in_command_FIFO together; latch len_r and cmd_r=command_FIFO[1:0].
  - COMP: rd_in_data_FIFO high for exactly len_r consecutive cycles. Fold data_FIFO into the accumulator each cycle.
  - OUTPUT: one cycle. wr_out_fifo1=1, data_out=result_r.
- DONE: FC=1 for one cycle with next_mode_out driven, then return to IDLE.
- next_mode_out
  - SETUP_COMP: COMP if 1 ≤ length ≤ size; otherwise OUTPUT, with err set and result_r=0.
  - COMP: OUTPUT.
  - OUTPUT: SETUP_COMP.
- Commands
  - 00 sum: accumulator width+clog2(size+1) bits; result saturates to 2^width−1.
  - 01 max, 10 min.
  - 11 is treated as sum.
- result_r loads from the accumulator at the end of COMP.
- next_mode_in=11 is illegal. Go straight through START/RUN with no FIFO or write activity; FC with next_mode_out=SETUP_COMP; err unaffected.
- invoke while not IDLE: ignored.
- Enable checking (token availability) is the scheduler's job. The block assumes FIFOs are non-empty/non-full when invoked.
- Reset, including mid-firing: asynchronous return to IDLE. Clears mode_r, len_r, cmd_r, accumulator, counter, result_r and err. No FC is issued for the aborted firing.

## Timing
- Reset values: every output 0 (next_mode_out=00, FC=0, all strobes 0, data_out=0, err=0).
- Latency: invoke sampled at edge t → START in cycle t+1 → RUN from t+2.
  - FC at t+3 for SETUP_COMP, OUTPUT and illegal modes.
  - FC at t+2+L for COMP.
- Strobes, FC, next_mode_out and data_out are registered-state decodes: no combinational path from any input to any output.
- Back-to-back: invoke may be high in the FC cycle, but is first sampled in the following IDLE cycle. Minimum firing period is 4 cycles (3+L for COMP).
- err sets in the RUN cycle of SETUP_COMP and stays set until reset.

## Test plan
- Reset: hold rst=0 for 3 cycles then release, with width=10, size=3 → all outputs 0, state IDLE. Assert rst=0 during COMP cycle 2 → FC never pulses and no further pops.
- SETUP then sum: length=3, cmd=0 → FC at t+3 with next_mode_out=01. COMP with data 5,7,9 → exactly 3 data pops, next_mode_out=10. OUTPUT → single write of data_out=21, next_mode_out=00.
- max/min: cmd=1 over 4,12,2 → 12. cmd=2 over the same data → 2.
- Saturation: cmd=0, L=3, data 1023,1023,1023 → data_out=1023.
- Illegal length: length=0 → err=1, next_mode_out=10. OUTPUT writes 0. Repeat with length=4 (> size) → same.
- Protocol: next_mode_in=11 → FC at t+3, no strobes. Invoke held high during RUN → no extra firing. Invoke in the FC cycle → next firing starts one cycle later.

Source files
------------

// File: rtl/stream_window_reduce_invoke.sv
// Window-reduce CFDF actor: SETUP_COMP latches length/command, COMP folds
// len_r data tokens (sum/max/min), OUTPUT writes one result token.
//
// Ports:
//   clk, rst (async, active-low)
//   data_FIFO / length_FIFO / command_FIFO : FWFT head tokens
//   invoke, next_mode_in                   : scheduler firing request
//   rd_in_*_FIFO                           : pop strobes
//   next_mode_out, FC                      : firing-complete handshake
//   wr_out_fifo1, data_out                 : result write
//   err                                    : sticky illegal-length flag
module stream_window_reduce_invoke #(
   parameter int size  = 3,
   parameter int width = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [width-1:0] data_FIFO,
   input  logic [width-1:0] length_FIFO,
   input  logic [width-1:0] command_FIFO,
   input  logic             invoke,
   input  logic [1:0]       next_mode_in,
   output logic             rd_in_data_FIFO,
   output logic             rd_in_length_FIFO,
   output logic             rd_in_command_FIFO,
   output logic [1:0]       next_mode_out,
   output logic             FC,
   output logic             wr_out_fifo1,
   output logic [width-1:0] data_out,
   output logic             err
);

   localparam int AW = width + $clog2(size + 1);
   localparam logic [width-1:0] SIZE_W = width'(size);
   localparam logic [AW-1:0] SAT = AW'({width{1'b1}});

   localparam logic [1:0] M_SETUP = 2'b00;
   localparam logic [1:0] M_COMP  = 2'b01;
   localparam logic [1:0] M_OUT   = 2'b10;
   localparam logic [1:0] C_MAX   = 2'b01;
   localparam logic [1:0] C_MIN   = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      START,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [1:0]       cmd_q, cmd_d;
   logic [width-1:0] len_q, len_d;
   logic [width-1:0] cnt_q, cnt_d;
   logic [width-1:0] result_q, result_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic             err_q, err_d;

   logic [width:0]   cnt_inc;
   logic             pop;
   logic             last;
   logic             len_in_ok;
   logic             len_q_ok;
   logic [AW-1:0]    din;
   logic [AW-1:0]    fold;
   logic [AW-1:0]    acc_new;
   logic [width-1:0] reduced;
   logic             unused_cmd_hi;

   assign unused_cmd_hi = ^command_FIFO[width-1:2];

   assign len_in_ok = (length_FIFO != '0) && (length_FIFO <= SIZE_W);
   assign len_q_ok  = (len_q != '0) && (len_q <= SIZE_W);

   // Pops stop once len_r tokens are taken; a zero length never pops.
   assign cnt_inc = {1'b0, cnt_q} + (width + 1)'(1);
   assign pop     = (state_q == RUN) && (mode_q == M_COMP) && (cnt_q < len_q);
   assign last    = cnt_inc >= {1'b0, len_q};
   assign din     = AW'(data_FIFO);

   always_comb begin
      fold = acc_q + din;
      unique case (1'b1)
         cmd_q == C_MAX: fold = (din > acc_q) ? din : acc_q;
         cmd_q == C_MIN: fold = (din < acc_q) ? din : acc_q;
         default: ;
      endcase
   end

   // Sum (and command 11) saturates; max/min always fit in width bits.
   always_comb begin
      acc_new = pop ? fold : acc_q;
      reduced = acc_new[width-1:0];
      if (cmd_q != C_MAX && cmd_q != C_MIN && acc_new > SAT) begin
         reduced = SAT[width-1:0];
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (invoke) state_d = START;
         START:   state_d = RUN;
         RUN:     if (mode_q != M_COMP || last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath
   always_comb begin
      mode_d   = mode_q;
      cmd_d    = cmd_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      result_d = result_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (invoke) mode_d = next_mode_in;
         end
         START: begin
            if (mode_q == M_COMP) begin
               cnt_d = '0;
               acc_d = (cmd_q == C_MIN) ? '1 : '0;
            end
         end
         RUN: begin
            if (mode_q == M_SETUP) begin
               len_d = length_FIFO;
               cmd_d = command_FIFO[1:0];
               if (!len_in_ok) begin
                  err_d    = 1'b1;
                  result_d = '0;
               end
            end else if (mode_q == M_COMP) begin
               acc_d = acc_new;
               if (pop) cnt_d = cnt_inc[width-1:0];
               if (last) result_d = reduced;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q   <= M_SETUP;
         cmd_q    <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         cmd_q    <= cmd_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   // Outputs: decodes of registered state only
   always_comb begin
      rd_in_data_FIFO    = pop;
      rd_in_length_FIFO  = 1'b0;
      rd_in_command_FIFO = 1'b0;
      wr_out_fifo1       = 1'b0;
      data_out           = '0;
      FC                 = 1'b0;
      next_mode_out      = M_SETUP;
      err                = err_q;
      if (state_q == RUN) begin
         rd_in_length_FIFO  = (mode_q == M_SETUP);
         rd_in_command_FIFO = (mode_q == M_SETUP);
         wr_out_fifo1       = (mode_q == M_OUT);
         if (mode_q == M_OUT) data_out = result_q;
      end
      if (state_q == DONE) begin
         FC = 1'b1;
         case (mode_q)
            M_SETUP: next_mode_out = len_q_ok ? M_COMP : M_OUT;
            M_COMP:  next_mode_out = M_OUT;
            default: next_mode_out = M_SETUP;
         endcase
      end
   end

endmodule

// File: tb/tb_stream_window_reduce_invoke.sv
// Randomised bench for stream_window_reduce_invoke with a per-cycle
// expected-output timeline built from a token-level model.
module tb_stream_window_reduce_invoke;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] data_FIFO = '0;
   logic [9:0] length_FIFO = '0;
   logic [9:0] command_FIFO = '0;
   logic       invoke = 1'b0;
   logic [1:0] next_mode_in = '0;
   logic       rd_in_data_FIFO;
   logic       rd_in_length_FIFO;
   logic       rd_in_command_FIFO;
   logic [1:0] next_mode_out;
   logic       FC;
   logic       wr_out_fifo1;
   logic [9:0] data_out;
   logic       err;

   stream_window_reduce_invoke #(
      .size (3),
      .width(10)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .data_FIFO         (data_FIFO),
      .length_FIFO       (length_FIFO),
      .command_FIFO      (command_FIFO),
      .invoke            (invoke),
      .next_mode_in      (next_mode_in),
      .rd_in_data_FIFO   (rd_in_data_FIFO),
      .rd_in_length_FIFO (rd_in_length_FIFO),
      .rd_in_command_FIFO(rd_in_command_FIFO),
      .next_mode_out     (next_mode_out),
      .FC                (FC),
      .wr_out_fifo1      (wr_out_fifo1),
      .data_out          (data_out),
      .err               (err)
   );

   typedef struct packed {
      logic       rdd;
      logic       rdl;
      logic       rdc;
      logic       wr;
      logic [9:0] dout;
      logic       fc;
      logic [1:0] nmo;
      logic       err;
   } ev_t;

   ev_t        exp_m[int];
   ev_t        ce;
   ev_t        ca;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   bit         run_cmp = 0;
   logic       cur_err = 1'b0;
   int         last_wr = -1;
   logic [9:0] dq[$];
   int         pend[$];
   bit         rd_ng = 0;
   int         m_len = 0;
   int         m_cmd = 0;
   int         m_res = 0;
   logic       m_err = 1'b0;
   logic [1:0] nm = '0;
   logic [1:0] sch = '0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic head();
      data_FIFO = (dq.size() > 0) ? dq[0] : 10'($urandom);
   endtask

   // FWFT data FIFO: strobe seen mid-cycle pops the head after the edge
   always @(negedge clk) rd_ng = rd_in_data_FIFO;
   always @(posedge clk) begin
      #1;
      if (rd_ng && dq.size() > 0) void'(dq.pop_front());
      rd_ng = 0;
      head();
   end

   always @(negedge clk) begin
      if (run_cmp) begin
         if (exp_m.exists(cyc)) begin
            ce = exp_m[cyc];
            exp_m.delete(cyc);
         end else begin
            ce = '0;
            ce.err = cur_err;
         end
         cur_err = ce.err;
         ca = {rd_in_data_FIFO, rd_in_length_FIFO, rd_in_command_FIFO,
               wr_out_fifo1, data_out, FC, next_mode_out, err};
         n_cmp++;
         if (ca !== ce) begin
            n_bad++;
            $display("FAIL cycle %0d outputs: got %05h required %05h",
                     cyc, ca, ce);
         end
         if (wr_out_fifo1) last_wr = int'(data_out);
      end
   end

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called just after an edge; returns in the DONE (FC) cycle.
   task automatic fire(input logic [1:0] m, input int lt, input int ct,
                       input bit hold);
      int  c;
      int  d;
      int  acc;
      bit  ok;
      ev_t er;
      ev_t ed;
      c = cyc;
      length_FIFO  = 10'(lt);
      command_FIFO = 10'(ct);
      next_mode_in = m;
      invoke       = 1'b1;
      er = '0;
      er.err = m_err;
      exp_m[c+1] = er;
      d = 3;
      case (m)
         2'd0: begin
            ok = (lt >= 1) && (lt <= 3);
            er.rdl = 1'b1;
            er.rdc = 1'b1;
            exp_m[c+2] = er;
            m_len = lt;
            m_cmd = ct % 4;
            if (!ok) begin
               m_err = 1'b1;
               m_res = 0;
            end
            nm = ok ? 2'd1 : 2'd2;
         end
         2'd1: begin
            er.rdd = 1'b1;
            acc = (m_cmd == 2) ? 1023 : 0;
            for (int i = 0; i < m_len; i++) begin
               int v;
               v = (pend.size() > 0) ? pend.pop_front() : int'($urandom % 1024);
               dq.push_back(10'(v));
               if (m_cmd == 1) acc = (v > acc) ? v : acc;
               else if (m_cmd == 2) acc = (v < acc) ? v : acc;
               else acc = acc + v;
               exp_m[c+2+i] = er;
            end
            if (m_cmd != 1 && m_cmd != 2 && acc > 1023) acc = 1023;
            m_res = acc;
            d = 2 + m_len;
            nm = 2'd2;
            head();
         end
         2'd2: begin
            er.wr = 1'b1;
            er.dout = 10'(m_res);
            exp_m[c+2] = er;
            nm = 2'd0;
         end
         default: begin
            exp_m[c+2] = er;
            nm = 2'd0;
         end
      endcase
      ed = '0;
      ed.fc = 1'b1;
      ed.nmo = nm;
      ed.err = m_err;
      exp_m[c+d] = ed;
      tick();
      if (!hold) invoke = 1'b0;
      next_mode_in = 2'($urandom);
      repeat (d - 1) tick();
      invoke = 1'b0;
   endtask

   // From an FC cycle to the next IDLE cycle where a firing may start.
   task automatic space(input bit early, input int gap);
      if (early) begin
         invoke = 1'b1;
         tick();
      end else begin
         repeat (1 + gap) tick();
      end
   endtask

   task automatic window(input int lt, input int ct, input int a,
                         input int b, input int c3, input int req);
      space(0, 0);
      fire(2'd0, lt, ct, 0);
      pend.push_back(a);
      pend.push_back(b);
      pend.push_back(c3);
      space(0, 0);
      fire(2'd1, 0, 0, 0);
      chk("model_result", m_res, req);
      last_wr = -1;
      space(1, 0);
      fire(2'd2, 0, 0, 0);
      chk("window_out", last_wr, req);
   endtask

   initial begin
      int c;
      ev_t e0;
      #2 rst = 1'b0;
      #1 run_cmp = 1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      head();

      space(0, 0);
      fire(2'd0, 3, 0, 0);
      chk("setup_nm", int'(nm), 1);
      pend = '{5, 7, 9};
      space(0, 1);
      fire(2'd1, 0, 0, 1);
      chk("sum_model", m_res, 21);
      last_wr = -1;
      space(0, 0);
      fire(2'd2, 0, 0, 0);
      chk("sum_out", last_wr, 21);

      window(3, 1, 4, 12, 2, 12);
      window(3, 2, 4, 12, 2, 2);
      window(3, 0, 1023, 1023, 1023, 1023);
      window(3, 3, 100, 200, 300, 600);

      space(0, 0);
      fire(2'd0, 0, 0, 0);
      chk("len0_nm", int'(nm), 2);
      last_wr = -1;
      space(0, 0);
      fire(2'd2, 0, 0, 0);
      chk("len0_out", last_wr, 0);
      chk("err_sticky", int'(err), 1);
      space(0, 0);
      fire(2'd0, 4, 1, 0);
      chk("len4_nm", int'(nm), 2);
      space(1, 0);
      fire(2'd3, 0, 0, 1);
      chk("illegal_nm", int'(nm), 0);

      // Reset during the second COMP cycle aborts the firing
      space(0, 0);
      fire(2'd0, 3, 0, 0);
      space(0, 0);
      c = cyc;
      dq.push_back(10'd5);
      dq.push_back(10'd7);
      dq.push_back(10'd9);
      head();
      next_mode_in = 2'd1;
      invoke = 1'b1;
      e0 = '0;
      e0.err = m_err;
      exp_m[c+1] = e0;
      e0.rdd = 1'b1;
      exp_m[c+2] = e0;
      tick();
      invoke = 1'b0;
      tick();
      tick();
      #2 rst = 1'b0;
      exp_m.delete();
      cur_err = 1'b0;
      m_err = 1'b0;
      m_len = 0;
      m_cmd = 0;
      m_res = 0;
      dq.delete();
      head();
      repeat (3) tick();
      rst = 1'b1;
      chk("err_after_rst", int'(err), 0);

      sch = 2'd0;
      space(0, 0);
      for (int i = 0; i < 160; i++) begin
         int  lt;
         int  ct;
         bit  hold;
         hold = ($urandom % 4) == 0;
         if (($urandom % 10) == 0) begin
            fire(2'd3, int'($urandom % 1024), int'($urandom % 1024), hold);
         end else if (sch == 2'd0) begin
            lt = (($urandom % 4) == 0) ? int'($urandom % 1024)
                                       : int'($urandom % 6);
            ct = int'($urandom % 1024);
            fire(2'd0, lt, ct, hold);
            sch = nm;
         end else if (sch == 2'd1) begin
            for (int k = 0; k < m_len; k++) begin
               pend.push_back((($urandom % 4) == 0) ? 1023
                                                    : int'($urandom % 1024));
            end
            fire(2'd1, 0, 0, hold);
            sch = 2'd2;
         end else begin
            fire(2'd2, 0, 0, hold);
            sch = 2'd0;
         end
         space(($urandom % 4) == 0, int'($urandom % 3));
      end
      repeat (3) tick();
      chk("timeline_drained", exp_m.num(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
